// File: rtl/uart_tx_serializer.sv
// UART transmit engine: one byte per TxD_start, framed as start, LSB-first data,
// optional parity and 1-2 stop bits. busy covers the whole frame, done marks its end.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 2) begin : g_bad_params
    $error("uart_tx_serializer: unsupported parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          par_bit, par_bit_d;
  logic          txd_d;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      TxD      <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      par_bit  <= par_bit_d;
      TxD      <= txd_d;
    end
  end

  assign tick = (baud_cnt == BAUD_LAST);
  assign busy = (state != IDLE);

  always_comb begin
    state_d    = state;
    baud_cnt_d = tick ? '0 : baud_cnt + 1'b1;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    par_bit_d  = par_bit;
    done       = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        if (TxD_start) begin
          shreg_d   = TxD_data & DATA_MASK;
          // even parity is the XOR of the data bits; odd parity inverts it
          par_bit_d = (^(TxD_data & DATA_MASK)) ^ (PARITY == 2);
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == STOP_LAST) begin
            done      = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // line level is registered from the next state so it moves with the state change
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PAR:     txd_d = par_bit_d;
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench: four serializer configurations (8N1, 8E1, 8O1, 7N2) at 16 clk/bit share
// one stimulus stream; each line is compared cycle by cycle with a slot-level frame model.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       txd [4];
  logic       busy [4];
  logic       done [4];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .TxD_start(start), .TxD_data(data), .TxD(txd[0]), .busy(busy[0]), .done(done[0]));
  uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .TxD_start(start), .TxD_data(data), .TxD(txd[1]), .busy(busy[1]), .done(done[1]));
  uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .TxD_start(start), .TxD_data(data), .TxD(txd[2]), .busy(busy[2]), .done(done[2]));
  uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .TxD_start(start), .TxD_data(data), .TxD(txd[3]), .busy(busy[3]), .done(done[3]));

  function automatic int db_of(int k);   return (k == 3) ? 7 : 8; endfunction
  function automatic int par_of(int k);  return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction
  function automatic int stop_of(int k); return (k == 3) ? 2 : 1; endfunction

  function automatic int frame_len(int k);
    return 16 * (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + stop_of(k));
  endfunction

  // expected line level during frame cycle c (cycle 0 = first cycle after the accepting edge)
  function automatic logic exp_line(int k, logic [7:0] d, int c);
    int  slot;
    int  ones;
    if (c >= frame_len(k)) return 1'b1;
    slot = c / 16;
    if (slot == 0) return 1'b0;
    if (slot <= db_of(k)) return d[slot-1];
    if (par_of(k) != 0 && slot == db_of(k) + 1) begin
      ones = 0;
      for (int i = 0; i < db_of(k); i++) ones += d[i];
      return (par_of(k) == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag, int c, logic [7:0] d);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s k%0d c%0d txd", tag, k, c), txd[k], exp_line(k, d, c));
      chk($sformatf("%s k%0d c%0d busy", tag, k, c), busy[k], logic'(c < frame_len(k)));
      chk($sformatf("%s k%0d c%0d done", tag, k, c), done[k], logic'(c == frame_len(k) - 1));
    end
  endtask

  // send one byte with a 1-cycle pulse; optionally inject a second request mid-frame
  task automatic send(string tag, logic [7:0] d, int inject_at, logic [7:0] inj);
    @(posedge clk); #1;
    start = 1'b1;
    data  = d;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 180; c++) begin
      @(negedge clk);
      check_all(tag, c, d);
      if (c == inject_at) begin
        start = 1'b1;
        data  = inj;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic check_idle(string tag, int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s k%0d c%0d txd", tag, k, c), txd[k], 1'b1);
        chk($sformatf("%s k%0d c%0d busy", tag, k, c), busy[k], 1'b0);
        chk($sformatf("%s k%0d c%0d done", tag, k, c), done[k], 1'b0);
      end
    end
  endtask

  initial begin
    logic [7:0] rnd;

    // reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("idle", 100);

    // directed frames: A5 basic, 07 parity
    send("a5", 8'hA5, -1, 8'h00);
    send("07", 8'h07, -1, 8'h00);
    send("ff", 8'hFF, -1, 8'h00);

    // random bytes
    for (int n = 0; n < 6; n++) begin
      rnd = 8'($urandom);
      send($sformatf("rnd%0d", n), rnd, -1, 8'h00);
    end

    // request mid-frame must be ignored, data change has no effect
    send("ign", 8'h3C, 50, 8'h11);

    // back-to-back: start held high through the end of a frame
    @(posedge clk); #1;
    start = 1'b1;
    data  = 8'h55;
    @(posedge clk);
    for (int c = 0; c <= 177; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (c < frame_len(k)) begin
          chk($sformatf("b2b k%0d c%0d txd", k, c), txd[k], exp_line(k, 8'h55, c));
          chk($sformatf("b2b k%0d c%0d busy", k, c), busy[k], 1'b1);
        end else if (c == frame_len(k)) begin
          chk($sformatf("b2b gap k%0d txd", k), txd[k], 1'b1);
          chk($sformatf("b2b gap k%0d busy", k), busy[k], 1'b0);
        end else if (c == frame_len(k) + 1) begin
          chk($sformatf("b2b restart k%0d txd", k), txd[k], 1'b0);
          chk($sformatf("b2b restart k%0d busy", k), busy[k], 1'b1);
        end
      end
    end
    start = 1'b0;
    repeat (200) @(posedge clk);
    check_idle("b2b_end", 5);

    // reset during data bit 3 of 8'h00
    @(posedge clk); #1;
    start = 1'b1;
    data  = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 69; c++) begin
      @(negedge clk);
      check_all("pre_rst", c, 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_mid k%0d txd", k), txd[k], 1'b1);
      chk($sformatf("rst_mid k%0d busy", k), busy[k], 1'b0);
      chk($sformatf("rst_mid k%0d done", k), done[k], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    check_idle("post_rst", 50);

    // a fresh frame is accepted after reset
    send("after_rst", 8'hC3, -1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
